// File: rtl/sram_controller_pkg.sv
// Shared types and sizes for the two-halfword SRAM controller.
package sram_controller_pkg;

    localparam int unsigned SRAM_ADDR_W       = 18;
    localparam int unsigned SRAM_DATA_W       = 16;
    localparam int unsigned BUS_W             = 32;
    localparam int unsigned WORD_W            = SRAM_ADDR_W - 1;
    localparam int unsigned DEFAULT_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bus between the pipeline and the SRAM controller.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic             wr_en;
    logic             rd_en;
    logic [BUS_W-1:0] address;
    logic [BUS_W-1:0] write_data;
    logic [BUS_W-1:0] read_data;
    logic             ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// 32-bit load/store over a 16-bit async SRAM as two halfword phases (LO, HI).
// Define SRAM_WAIT_EN to stretch each phase to WAIT_CYCLES+1 cycles.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    state_e                 state_q;
    logic                   is_wr_q;
    logic                   dq_oe_q;
    logic [SRAM_DATA_W-1:0] dq_q;
    logic [BUS_W-1:0]       read_data_q;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic                   we_n_q;
    logic                   oe_n_q;

    logic                   req_c;
    logic [BUS_W-1:0]       byte_off_c;
    logic [WORD_W-1:0]      word_c;
    logic                   phase_done_c;

    assign req_c      = bus.wr_en | bus.rd_en;
    assign byte_off_c = bus.address - BUS_W'(BASE_ADDR);
    assign word_c     = byte_off_c[WORD_W+1:2];

`ifdef SRAM_WAIT_EN
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             unused_c;

    assign phase_done_c = (cnt_q == CNT_W'(WAIT_CYCLES));
    assign unused_c     = ^{byte_off_c[BUS_W-1:WORD_W+2], byte_off_c[1:0]};

    // Counts cycles spent in the current phase; idles at zero outside LO/HI.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == LO || state_q == HI) && !phase_done_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end
`else
    logic unused_c;

    assign phase_done_c = 1'b1;
    assign unused_c     = ^{byte_off_c[BUS_W-1:WORD_W+2], byte_off_c[1:0], WAIT_CYCLES};
`endif

    // Phase sequencer; SRAM pins are registered so they are stable for the whole phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            dq_oe_q     <= 1'b0;
            dq_q        <= '0;
            read_data_q <= '0;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_c) begin
                        state_q <= LO;
                        is_wr_q <= bus.wr_en;
                        addr_q  <= {word_c, 1'b0};
                        we_n_q  <= ~bus.wr_en;
                        oe_n_q  <= bus.wr_en;
                        dq_oe_q <= bus.wr_en;
                        dq_q    <= bus.write_data[SRAM_DATA_W-1:0];
                    end
                end
                LO: begin
                    if (phase_done_c) begin
                        state_q <= HI;
                        addr_q  <= {addr_q[SRAM_ADDR_W-1:1], 1'b1};
                        dq_q    <= bus.write_data[BUS_W-1:SRAM_DATA_W];
                        if (!is_wr_q) begin
                            read_data_q[SRAM_DATA_W-1:0] <= SRAM_DQ;
                        end
                    end
                end
                HI: begin
                    if (phase_done_c) begin
                        state_q <= DONE;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        if (!is_wr_q) begin
                            read_data_q[BUS_W-1:SRAM_DATA_W] <= SRAM_DQ;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state_q == DONE) || ((state_q == IDLE) && !req_c);
    assign bus.read_data = read_data_q;

    assign SRAM_DQ   = dq_oe_q ? dq_q : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: pin-level SRAM device plus a word-level reference memory.
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int unsigned BASE  = DEFAULT_BASE_ADDR;
    localparam int unsigned WAITC = 2;
`ifdef SRAM_WAIT_EN
    localparam int unsigned PH = WAITC + 1;
`else
    localparam int unsigned PH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd = 32'h0;

    logic [15:0] mem [0:(1 << 18) - 1];
    logic [31:0] ref_mem [int unsigned];

    sram_controller_if bus ();

    sram_controller #(
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .SRAM_DQ  (sram_dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n),
        .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM device: drives on OE with WE high, latches while WE is low.
    assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!we_n) mem[sram_addr] <= sram_dq;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int unsigned ref_word(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off / 4) % 131072;
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // Starts one cycle into IDLE (#1 after an edge); returns #1 into DONE with the request still held.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        int unsigned w;
        logic        is_wr;
        w      = ref_word(addr);
        is_wr  = wr;
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = addr;
        bus.write_data = wdata;
        #1;
        chk(tag, "ready_on_req", 32'(bus.ready), 32'h0);
        for (int unsigned ph = 0; ph < 2; ph++) begin
            for (int unsigned k = 0; k < PH; k++) begin
                @(posedge clk); #1;
                chk(tag, "sram_addr", 32'(sram_addr), w * 2 + ph);
                chk(tag, "we_n", 32'(we_n), 32'(!is_wr));
                chk(tag, "oe_n", 32'(oe_n), 32'(is_wr));
                chk(tag, "ready_busy", 32'(bus.ready), 32'h0);
                if (is_wr) chk(tag, "dq", 32'(sram_dq), (ph == 0) ? 32'(wdata[15:0]) : 32'(wdata[31:16]));
            end
        end
        @(posedge clk); #1;
        if (is_wr) ref_mem[w] = wdata;
        else       exp_rd = ref_read(w);
        chk(tag, "ready_done", 32'(bus.ready), 32'h1);
        chk(tag, "we_n_done", 32'(we_n), 32'h1);
        chk(tag, "oe_n_done", 32'(oe_n), 32'h1);
        chk(tag, "read_data", bus.read_data, exp_rd);
    endtask

    task automatic idle(input string tag);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk); #1;
        chk(tag, "ready_idle", 32'(bus.ready), 32'h1);
        chk(tag, "we_n_idle", 32'(we_n), 32'h1);
        chk(tag, "oe_n_idle", 32'(oe_n), 32'h1);
        chk(tag, "read_hold", bus.read_data, exp_rd);
    endtask

    initial begin
        for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0;
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "ready", 32'(bus.ready), 32'h1);
        chk("reset", "we_n", 32'(we_n), 32'h1);
        chk("reset", "oe_n", 32'(oe_n), 32'h1);
        chk("reset", "sram_addr", 32'(sram_addr), 32'h0);
        chk("reset", "read_data", bus.read_data, 32'h0);
        chk("reset", "ce_ub_lb", 32'({ce_n, ub_n, lb_n}), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "wr_base");
        idle("wr_base");
        access(1'b0, 1'b1, 32'd1024, 32'h0, "rd_base");
        chk("rd_base", "value", bus.read_data, 32'hDEADBEEF);
        idle("rd_base");

        mem[4] = 16'h5678;
        mem[5] = 16'h1234;
        ref_mem[2] = 32'h12345678;
        access(1'b0, 1'b1, 32'd1032, 32'h0, "rd_word2");
        chk("rd_word2", "value", bus.read_data, 32'h12345678);
        idle("rd_word2");

        access(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, "below_base");
        chk("below_base", "hi_addr", 32'(sram_addr), 32'h3FFFF);
        idle("below_base");
        access(1'b0, 1'b1, 32'd1020, 32'h0, "below_base_rd");
        idle("below_base_rd");

        access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, "both");
        idle("both");
        access(1'b0, 1'b1, 32'd1040, 32'h0, "both_rd");
        chk("both_rd", "value", bus.read_data, 32'hCAFEF00D);
        idle("both_rd");

        // Request held through DONE must not start a new access until IDLE.
        access(1'b0, 1'b1, 32'd1024, 32'h0, "b2b_a");
        @(posedge clk); #1;
        chk("b2b", "ready_idle_req", 32'(bus.ready), 32'h0);
        chk("b2b", "we_n_idle", 32'(we_n), 32'h1);
        chk("b2b", "oe_n_idle", 32'(oe_n), 32'h1);
        access(1'b1, 1'b0, 32'd1028, 32'h0BADCAFE, "b2b_b");
        idle("b2b_b");

        // Reset while a write is in its HI phase.
        bus.wr_en      = 1'b1;
        bus.rd_en      = 1'b1;
        bus.address    = 32'd1044;
        bus.write_data = 32'h11112222;
        @(posedge clk); #1;
        chk("rst_hi", "oe_n_both", 32'(oe_n), 32'h1);
        chk("rst_hi", "we_n_lo", 32'(we_n), 32'h0);
        repeat (PH) @(posedge clk);
        #1;
        chk("rst_hi", "in_hi_addr", 32'(sram_addr), ref_word(32'd1044) * 2 + 1);
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk); #1;
        exp_rd = 32'h0;
        chk("rst_hi", "we_n", 32'(we_n), 32'h1);
        chk("rst_hi", "oe_n", 32'(oe_n), 32'h1);
        chk("rst_hi", "sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_hi", "read_data", bus.read_data, 32'h0);
        chk("rst_hi", "ready", 32'(bus.ready), 32'h1);
        rst = 1'b0;
        idle("rst_hi");
        access(1'b1, 1'b0, 32'd1044, 32'h33334444, "rst_rewrite");
        idle("rst_rewrite");
        access(1'b0, 1'b1, 32'd1044, 32'h0, "rst_readback");
        chk("rst_readback", "value", bus.read_data, 32'h33334444);
        idle("rst_readback");

        for (int n = 0; n < 40; n++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) a = $urandom();
            else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            access(op != 1, op != 0, a, $urandom(), "rand");
            idle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 1024: byte address mapped to SRAM halfword 0.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra cycles per halfword access (used only with SRAM_WAIT_EN).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  in  1  MEM-stage write request, held stable while ready=0.
REQ-006 SHALL have port rd_en  in  1  MEM-stage read request, held stable while ready=0.
REQ-007 SHALL have port address  in  32  byte address from ALU result.
REQ-008 SHALL have port write_data  in  32  store data.
REQ-009 SHALL have port read_data  out  32  assembled load word, feeds MEM/WB register Mem_read_value_in.
REQ-010 SHALL have port ready  out  1  0 = freeze all pipeline registers.
REQ-011 SHALL have port SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SHALL have ports SRAM_ADDR out 18 and SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N out 1, all active-low strobes.

Function
REQ-013 SHALL implement FSM states IDLE, LO, HI, DONE.
REQ-014 SHALL move IDLE->LO when wr_en|rd_en; else stay IDLE.
REQ-015 SHALL move LO->HI and HI->DONE after each phase completes (1 cycle; WAIT_CYCLES+1 cycles with SRAM_WAIT_EN); DONE->IDLE unconditionally.
REQ-016 SHALL drive ready=1 in IDLE with no request and in DONE; ready=0 combinationally in IDLE with a request, and in LO and HI.
REQ-017 SHALL compute word = (address - BASE_ADDR) >> 2, modulo 2^17; SRAM_ADDR = {word[16:0], 0} in LO, {word[16:0], 1} in HI.
REQ-018 SHALL treat wr_en and rd_en asserted together as a write.
REQ-019 On write, SHALL drive SRAM_DQ = write_data[15:0] in LO and write_data[31:16] in HI, SRAM_WE_N=0 in those states; SRAM_DQ high-Z otherwise.
REQ-020 On read, SHALL hold SRAM_WE_N=1, SRAM_OE_N=0 in LO/HI, capture SRAM_DQ into read_data[15:0] at end of LO and read_data[31:16] at end of HI.
REQ-021 SHALL keep read_data stable from DONE until the next read's LO capture.
REQ-022 SHALL hold SRAM_CE_N=SRAM_UB_N=SRAM_LB_N=0 constantly; SRAM_WE_N=1 and SRAM_OE_N=1 in IDLE and DONE.
REQ-023 SHALL ignore wr_en/rd_en in DONE; the next request is accepted from IDLE the following cycle.
REQ-024 No-wait latency: request visible in cycle 0 (IDLE) -> ready=1 in cycle 3 (DONE).

Reset
REQ-025 rst in any state, including mid-LO/HI, SHALL on the next edge force IDLE, read_data=0, wait counter=0, SRAM_DQ high-Z, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0.
REQ-026 During reset, ready SHALL follow REQ-016 for IDLE; an interrupted write leaves SRAM contents undefined.

Configuration
REQ-027 Macro SRAM_WAIT_EN defined: SHALL include a counter holding each of LO and HI for WAIT_CYCLES+1 cycles, with address, data and strobes stable throughout and the read capture on the final cycle.
REQ-028 Macro SRAM_WAIT_EN undefined: SHALL have no counter; LO and HI last one cycle each and WAIT_CYCLES is ignored.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, LO, HI, DONE), SRAM_ADDR_W=18, SRAM_DATA_W=16 and the default BASE_ADDR.
REQ-030 There SHALL be no sub-module; the FSM, wait counter and tristate driver stay in one module.

Verification
REQ-031 Write, no wait: wr_en=1, address=1024, write_data=0xDEADBEEF -> SRAM_ADDR 0 with DQ 0xBEEF, then 1 with 0xDEAD, WE_N low both cycles, ready=1 in cycle 3.
REQ-032 Read back: rd_en=1, address=1024 -> read_data=0xDEADBEEF in DONE; ready low for exactly 3 cycles.
REQ-033 Address 1032, read, SRAM model word 2 = 0x12345678 -> SRAM_ADDR 4 then 5, read_data=0x12345678.
REQ-034 SRAM_WAIT_EN, WAIT_CYCLES=2: read -> LO and HI each 3 cycles, ready=1 in cycle 7, captured value correct.
REQ-035 wr_en=rd_en=1 -> write performed, OE_N stays 1; rst asserted in HI -> IDLE, DQ high-Z, WE_N=1 on the next edge, read_data=0.
REQ-036 Address 1020 (below base) -> SRAM_ADDR wraps to 0x3FFFE/0x3FFFF.
